// File: rtl/alu_seq_pkg.sv
// Shared types and 74181 function-select constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // The required mode m is noted on each constant; arithmetic selects also need cn.
    localparam logic [3:0] S_ADD    = 4'b1001;  // m=0, cn=1: A plus B
    localparam logic [3:0] S_SUB    = 4'b0110;  // m=0, cn=0: A minus B
    localparam logic [3:0] S_AND    = 4'b1011;  // m=1: A and B
    localparam logic [3:0] S_OR     = 4'b1110;  // m=1: A or B
    localparam logic [3:0] S_XOR    = 4'b0110;  // m=1: A xor B
    localparam logic [3:0] S_PASS_A = 4'b0000;  // m=0, cn=1: F = A

endpackage

// File: rtl/alu_nibble_seq_slice.sv
// Combinational 4-bit 74181-equivalent slice (active-high data, active-low carries).
module alu_nibble_seq_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       ci,
    output logic [3:0] f,
    output logic       co
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;

    // x and y mirror the chip's internal propagate/generate terms; arithmetic
    // is x + y + carry, logic is their XNOR, and Cn+4 is produced in both modes.
    always_comb begin
        x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        y   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
        sum = {1'b0, x} + {1'b0, y} + {4'b0000, ~ci};
        f   = m ? ~(x ^ y) : sum[3:0];
        co  = ~sum[4];
    end

endmodule

// File: rtl/alu_nibble_seq.sv
// Runs a 4*NIB-bit ALU operation through one shared 74181 slice, one nibble per clock,
// LSB nibble first, chaining the slice carry through a register.
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4*NIB-1:0] a,
    input  logic [4*NIB-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    output logic             busy,
    output logic             done,
    output logic [4*NIB-1:0] f,
    output logic             cn4,
    output logic             zero
);

    localparam int W    = 4 * NIB;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    shadow;
    logic [3:0]      s_reg;
    logic            m_reg;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [3:0]      a_nib;
    logic [3:0]      b_nib;
    logic [3:0]      slice_f;
    logic            slice_co;

    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IDXW'(i)) begin
                a_nib = a_reg[4*i +: 4];
                b_nib = b_reg[4*i +: 4];
            end
        end
    end

    alu_nibble_seq_slice u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .s  (s_reg),
        .m  (m_reg),
        .ci (carry),
        .f  (slice_f),
        .co (slice_co)
    );

    // Carry register idles at 1 (no carry) so a reset leaves the chain inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            shadow <= '0;
            s_reg  <= 4'h0;
            m_reg  <= 1'b0;
            carry  <= 1'b1;
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            f      <= '0;
            cn4    <= 1'b1;
            zero   <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        s_reg <= s;
                        m_reg <= m;
                        carry <= cn;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx == IDXW'(i)) begin
                            shadow[4*i +: 4] <= slice_f;
                        end
                    end
                    carry <= slice_co;
                    if (idx == LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    f     <= shadow;
                    cn4   <= carry;
                    zero  <= (shadow == '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed-vector bench for alu_nibble_seq (NIB=4) with hand-computed expected results.
module tb_alu_nibble_seq;
    import alu_seq_pkg::*;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cn;
    logic         busy;
    logic         done;
    logic [W-1:0] f;
    logic         cn4;
    logic         zero;

    int compare_count  = 0;
    int mismatch_count = 0;
    int cycles;
    int done_seen;

    alu_nibble_seq #(.NIB(NIB)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .m     (m),
        .cn    (cn),
        .busy  (busy),
        .done  (done),
        .f     (f),
        .cn4   (cn4),
        .zero  (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compare_count++;
        if (got !== exp) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives operands with start high across one rising edge (the accepting edge).
    task automatic applyStimulus(input logic [W-1:0] va, input logic [W-1:0] vb,
                                 input logic [3:0] vs, input logic vm, input logic vcn);
        a     = va;
        b     = vb;
        s     = vs;
        m     = vm;
        cn    = vcn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles from the accepting edge (counted as 1) until done is seen.
    task automatic waitDone(input string tag);
        cycles = 1;
        while (done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (done !== 1'b1) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic watchNoDone(input int n);
        done_seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0; b = '0; s = 4'h0; m = 1'b0; cn = 1'b1;
        #12;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_f", {16'd0, f}, 32'h0);
        checkOutput("rst_cn4", {31'd0, cn4}, 32'd1);
        checkOutput("rst_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ADD 0x1234 + 0x1111
        applyStimulus(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1);
        checkOutput("add_busy", {31'd0, busy}, 32'd1);
        checkOutput("add_f_stable", {16'd0, f}, 32'h0);
        waitDone("add");
        checkOutput("add_latency", cycles, 32'd6);
        checkOutput("add_f", {16'd0, f}, 32'h2345);
        checkOutput("add_cn4", {31'd0, cn4}, 32'd1);
        checkOutput("add_zero", {31'd0, zero}, 32'd0);
        checkOutput("add_busy_low", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_pulse_width", {31'd0, done}, 32'd0);

        // ADD overflow: carry ripples through every nibble
        applyStimulus(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1);
        waitDone("ovf");
        checkOutput("ovf_f", {16'd0, f}, 32'h0000);
        checkOutput("ovf_cn4", {31'd0, cn4}, 32'd0);
        checkOutput("ovf_zero", {31'd0, zero}, 32'd1);

        // SUB without and with borrow
        applyStimulus(16'h0005, 16'h0003, S_SUB, 1'b0, 1'b0);
        waitDone("sub1");
        checkOutput("sub1_f", {16'd0, f}, 32'h0002);
        checkOutput("sub1_cn4", {31'd0, cn4}, 32'd0);
        applyStimulus(16'h0003, 16'h0005, S_SUB, 1'b0, 1'b0);
        waitDone("sub2");
        checkOutput("sub2_f", {16'd0, f}, 32'hFFFE);
        checkOutput("sub2_cn4", {31'd0, cn4}, 32'd1);
        checkOutput("sub2_zero", {31'd0, zero}, 32'd0);

        // Logic AND still walks every nibble
        applyStimulus(16'hF0F0, 16'hFF00, S_AND, 1'b1, 1'b1);
        waitDone("and");
        checkOutput("and_latency", cycles, 32'd6);
        checkOutput("and_f", {16'd0, f}, 32'hF000);
        checkOutput("and_zero", {31'd0, zero}, 32'd0);

        // XOR and OR in logic mode
        applyStimulus(16'hA5A5, 16'h0FF0, S_XOR, 1'b1, 1'b1);
        waitDone("xor");
        checkOutput("xor_f", {16'd0, f}, 32'hAA55);
        applyStimulus(16'h1200, 16'h0034, S_OR, 1'b1, 1'b1);
        waitDone("or");
        checkOutput("or_f", {16'd0, f}, 32'h1234);

        // Start while busy is ignored and not queued
        applyStimulus(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1);
        checkOutput("busy_f_stable", {16'd0, f}, 32'h1234);
        waitDone("ign");
        checkOutput("ign_f", {16'd0, f}, 32'h2345);
        watchNoDone(10);
        checkOutput("ign_no_second_done", done_seen, 32'd0);

        // Start held in the done cycle is accepted back-to-back
        applyStimulus(16'h0F0F, 16'h0101, S_ADD, 1'b0, 1'b1);
        waitDone("b2b1");
        checkOutput("b2b1_f", {16'd0, f}, 32'h1010);
        a = 16'h0003; b = 16'h0003; s = S_ADD; m = 1'b0; cn = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_busy", {31'd0, busy}, 32'd1);
        waitDone("b2b2");
        checkOutput("b2b_spacing", cycles, 32'd6);
        checkOutput("b2b2_f", {16'd0, f}, 32'h0007);

        // Reset while idx==2 discards the operation immediately
        applyStimulus(16'h1234, 16'h1111, S_ADD, 1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_f", {16'd0, f}, 32'h0);
        checkOutput("mid_cn4", {31'd0, cn4}, 32'd1);
        checkOutput("mid_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        watchNoDone(10);
        checkOutput("mid_no_done", done_seen, 32'd0);
        applyStimulus(16'h0100, 16'h0023, S_ADD, 1'b0, 1'b1);
        waitDone("post");
        checkOutput("post_f", {16'd0, f}, 32'h0123);
        checkOutput("post_cn4", {31'd0, cn4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
